control_unit_mc: RTL and testbench

- Sequential, parametrised successor to the single-cycle opcode decoder. It registers decoded control signals and owns a multi-cycle FSM that stalls the PC for data-memory accesses (BUSYWAIT handshake with the data cache) and for an iterative multiplier.
- Adds an extended ISA (bne, shifts, rotate, mult) and illegal-opcode trapping.
- Sits between the instruction-cache output and the register file, ALU, data cache and PC unit.

---
 rtl/cpu_isa_pkg.sv | 75 +++++++
 rtl/isa_decoder.sv | 54 +++++
 rtl/control_unit_mc.sv | 149 ++++++++++++++
 tb/tb_control_unit_mc.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcodes, ALU/shift encodings, decode classes,
// control-unit FSM state encoding and the registered control bundle.
package cpu_isa_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;
    localparam logic [7:0] OP_LWD   = 8'h08;
    localparam logic [7:0] OP_LWI   = 8'h09;
    localparam logic [7:0] OP_SWD   = 8'h0A;
    localparam logic [7:0] OP_SWI   = 8'h0B;
    localparam logic [7:0] OP_BNE   = 8'h0C;
    localparam logic [7:0] OP_SLL   = 8'h0D;
    localparam logic [7:0] OP_SRL   = 8'h0E;
    localparam logic [7:0] OP_SRA   = 8'h0F;
    localparam logic [7:0] OP_ROR   = 8'h10;
    localparam logic [7:0] OP_MULT  = 8'h11;

    localparam logic [2:0] ALU_FWD   = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_MULT  = 3'b100;
    localparam logic [2:0] ALU_SHIFT = 3'b101;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Instruction classes reported by the decoder to the sequencing FSM
    localparam logic [1:0] CLS_SINGLE  = 2'd0;
    localparam logic [1:0] CLS_MEM     = 2'd1;
    localparam logic [1:0] CLS_MULT    = 2'd2;
    localparam logic [1:0] CLS_ILLEGAL = 2'd3;

    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_MEM      = 3'd1;
    localparam logic [2:0] ST_MEM_DONE = 3'd2;
    localparam logic [2:0] ST_MULT     = 3'd3;
    localparam logic [2:0] ST_ILLEGAL  = 3'd4;

    typedef struct packed {
        logic [2:0] aluop;
        logic [1:0] shiftmode;
        logic       we;
        logic       twoscomp;
        logic       immed;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       wmux;
        logic       read;
        logic       write;
    } ctrl_t;

    // Drop every side-effecting enable while keeping datapath selects as-is
    function automatic ctrl_t clear_enables(input ctrl_t c);
        ctrl_t r;
        r        = c;
        r.we     = 1'b0;
        r.branch = 1'b0;
        r.bne    = 1'b0;
        r.jump   = 1'b0;
        r.read   = 1'b0;
        r.write  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/isa_decoder.sv
// Combinational opcode decoder: produces the control bundle for an opcode
// and classifies it as single-cycle, memory, multiply or illegal.
module isa_decoder
    import cpu_isa_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int EXT_ISA  = 1
)(
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_t               o_ctrl,
    output logic [1:0]          o_cls
);

    localparam bit EXT = (EXT_ISA != 0);

    // Opcode to control bundle; anything unmatched (or extended ops when
    // the extension is disabled) is classed illegal
    always_comb begin
        o_ctrl = '0;
        o_cls  = CLS_SINGLE;
        case (i_opcode)
            OPCODE_W'(OP_LOADI): begin o_ctrl.immed = 1'b1; o_ctrl.we = 1'b1; end
            OPCODE_W'(OP_MOV):   o_ctrl.we = 1'b1;
            OPCODE_W'(OP_ADD):   begin o_ctrl.aluop = ALU_ADD; o_ctrl.we = 1'b1; end
            OPCODE_W'(OP_SUB):   begin o_ctrl.aluop = ALU_ADD; o_ctrl.twoscomp = 1'b1; o_ctrl.we = 1'b1; end
            OPCODE_W'(OP_AND):   begin o_ctrl.aluop = ALU_AND; o_ctrl.we = 1'b1; end
            OPCODE_W'(OP_OR):    begin o_ctrl.aluop = ALU_OR;  o_ctrl.we = 1'b1; end
            OPCODE_W'(OP_J):     o_ctrl.jump = 1'b1;
            OPCODE_W'(OP_BEQ):   begin o_ctrl.aluop = ALU_ADD; o_ctrl.twoscomp = 1'b1; o_ctrl.branch = 1'b1; end
            OPCODE_W'(OP_LWD):   begin o_ctrl.read = 1'b1; o_ctrl.wmux = 1'b1; o_cls = CLS_MEM; end
            OPCODE_W'(OP_LWI):   begin o_ctrl.read = 1'b1; o_ctrl.wmux = 1'b1; o_ctrl.immed = 1'b1; o_cls = CLS_MEM; end
            OPCODE_W'(OP_SWD):   begin o_ctrl.write = 1'b1; o_cls = CLS_MEM; end
            OPCODE_W'(OP_SWI):   begin o_ctrl.write = 1'b1; o_ctrl.immed = 1'b1; o_cls = CLS_MEM; end
            OPCODE_W'(OP_BNE): begin
                if (EXT) begin o_ctrl.aluop = ALU_ADD; o_ctrl.twoscomp = 1'b1; o_ctrl.bne = 1'b1; end
                else o_cls = CLS_ILLEGAL;
            end
            OPCODE_W'(OP_SLL), OPCODE_W'(OP_SRL), OPCODE_W'(OP_SRA), OPCODE_W'(OP_ROR): begin
                if (EXT) begin
                    o_ctrl.aluop     = ALU_SHIFT;
                    o_ctrl.shiftmode = 2'(i_opcode - OPCODE_W'(OP_SLL));
                    o_ctrl.immed     = 1'b1;
                    o_ctrl.we        = 1'b1;
                end else o_cls = CLS_ILLEGAL;
            end
            OPCODE_W'(OP_MULT): begin
                if (EXT) begin o_ctrl.aluop = ALU_MULT; o_ctrl.we = 1'b1; o_cls = CLS_MULT; end
                else o_cls = CLS_ILLEGAL;
            end
            default: o_cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: registers decoded controls and sequences
// data-memory accesses and the iterative multiplier by holding the PC.
module control_unit_mc
    import cpu_isa_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int OPCODE_W    = 8,
    parameter int ALUOP_W     = 3,
    parameter int EXT_ISA     = 1,
    parameter int MULT_CYCLES = 4
)(
    input  logic               CLK,
    input  logic               RESET,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic               INSTR_VALID,
    input  logic               BUSYWAIT,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic [1:0]         SHIFTMODE,
    output logic               WRITEENABLE,
    output logic               TWOSCOMPMUX_SEL,
    output logic               IMMEDMUX_SEL,
    output logic               BRANCHENABLE,
    output logic               BNEENABLE,
    output logic               JUMPENABLE,
    output logic               WRITEMUX_SEL,
    output logic               READ,
    output logic               WRITE,
    output logic               PC_HOLD,
    output logic               ILLEGAL
);

    ctrl_t      w_dec, r_ctrl, w_ctrl_nxt;
    logic [1:0] w_cls;
    logic [2:0] r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_pc_hold, w_pc_hold_nxt;
    logic       r_illegal, w_illegal_nxt;
    logic       r_mem_load, w_mem_load_nxt;
    logic       w_unused_low;

    assign w_unused_low = ^INSTRUCTION[INSTR_W-OPCODE_W-1:0];

    isa_decoder #(
        .OPCODE_W (OPCODE_W),
        .EXT_ISA  (EXT_ISA)
    ) u_dec (
        .i_opcode (INSTRUCTION[INSTR_W-1 -: OPCODE_W]),
        .o_ctrl   (w_dec),
        .o_cls    (w_cls)
    );

    // Next-state and next-control computation for the sequencing FSM
    always_comb begin
        w_ctrl_nxt     = r_ctrl;
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pc_hold_nxt  = r_pc_hold;
        w_illegal_nxt  = r_illegal;
        w_mem_load_nxt = r_mem_load;
        case (r_state)
            // The memory completion cycle releases the PC, so the instruction
            // presented during it is decoded exactly as in RUN
            ST_RUN, ST_MEM_DONE: begin
                w_state_nxt   = ST_RUN;
                w_pc_hold_nxt = 1'b0;
                w_ctrl_nxt    = clear_enables(r_ctrl);
                if (INSTR_VALID) begin
                    case (w_cls)
                        CLS_SINGLE: w_ctrl_nxt = w_dec;
                        CLS_MEM: begin
                            w_ctrl_nxt     = w_dec;
                            w_pc_hold_nxt  = 1'b1;
                            w_state_nxt    = ST_MEM;
                            w_mem_load_nxt = w_dec.read;
                        end
                        CLS_MULT: begin
                            w_ctrl_nxt = w_dec;
                            if (MULT_CYCLES > 1) begin
                                w_ctrl_nxt.we = 1'b0;
                                w_pc_hold_nxt = 1'b1;
                                w_state_nxt   = ST_MULT;
                                w_cnt_nxt     = 4'(MULT_CYCLES - 1);
                            end
                        end
                        default: begin
                            w_illegal_nxt = 1'b1;
                            w_pc_hold_nxt = 1'b1;
                            w_state_nxt   = ST_ILLEGAL;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                if (!BUSYWAIT) begin
                    w_ctrl_nxt.read  = 1'b0;
                    w_ctrl_nxt.write = 1'b0;
                    w_ctrl_nxt.we    = r_mem_load;
                    w_pc_hold_nxt    = 1'b0;
                    w_state_nxt      = ST_MEM_DONE;
                end
            end
            // The final multiply cycle is a plain RUN cycle with WE raised
            ST_MULT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_ctrl_nxt.we = 1'b1;
                    w_pc_hold_nxt = 1'b0;
                    w_state_nxt   = ST_RUN;
                end
            end
            ST_ILLEGAL: ;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ctrl     <= '0;
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_pc_hold  <= 1'b0;
            r_illegal  <= 1'b0;
            r_mem_load <= 1'b0;
        end else begin
            r_ctrl     <= w_ctrl_nxt;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pc_hold  <= w_pc_hold_nxt;
            r_illegal  <= w_illegal_nxt;
            r_mem_load <= w_mem_load_nxt;
        end
    end

    assign ALUOP           = ALUOP_W'(r_ctrl.aluop);
    assign SHIFTMODE       = r_ctrl.shiftmode;
    assign WRITEENABLE     = r_ctrl.we;
    assign TWOSCOMPMUX_SEL = r_ctrl.twoscomp;
    assign IMMEDMUX_SEL    = r_ctrl.immed;
    assign BRANCHENABLE    = r_ctrl.branch;
    assign BNEENABLE       = r_ctrl.bne;
    assign JUMPENABLE      = r_ctrl.jump;
    assign WRITEMUX_SEL    = r_ctrl.wmux;
    assign READ            = r_ctrl.read;
    assign WRITE           = r_ctrl.write;
    assign PC_HOLD         = r_pc_hold;
    assign ILLEGAL         = r_illegal;

endmodule

// File: tb/tb_control_unit_mc.sv
// Scoreboard bench for control_unit_mc: three instances (extended ISA with
// 4-cycle mult, base ISA only, single-cycle mult) share the instruction stream.
module tb_control_unit_mc;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1, RESET0 = 1'b1;
    logic [31:0] instr = '0;
    logic        ivalid = 1'b0, busy = 1'b0;
    wire  [15:0] ov0, ov1, ov2;

    // Output vector packing: {IL,PH,WR,RD,WM,J,BNE,BR,IMM,TWOS,WE,SM[1:0],ALU[2:0]}
    localparam logic [15:0] WE_ = 16'h0020, TW = 16'h0040, IM = 16'h0080, BR = 16'h0100;
    localparam logic [15:0] BN = 16'h0200, JP = 16'h0400, WM = 16'h0800, RD = 16'h1000;
    localparam logic [15:0] WR = 16'h2000, PH = 16'h4000, IL = 16'h8000;
    localparam logic [15:0] M_ALL = 16'hFFFF, M_CORE = 16'hF727, M_NOALU = 16'hF720;

    typedef struct {
        string       tag;
        int          which;
        logic [15:0] exp;
        logic [15:0] mask;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0, n_miss = 0;

    always #5 CLK = ~CLK;

    control_unit_mc #(.EXT_ISA(1), .MULT_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(instr), .INSTR_VALID(ivalid), .BUSYWAIT(busy),
        .ALUOP(ov0[2:0]), .SHIFTMODE(ov0[4:3]), .WRITEENABLE(ov0[5]), .TWOSCOMPMUX_SEL(ov0[6]),
        .IMMEDMUX_SEL(ov0[7]), .BRANCHENABLE(ov0[8]), .BNEENABLE(ov0[9]), .JUMPENABLE(ov0[10]),
        .WRITEMUX_SEL(ov0[11]), .READ(ov0[12]), .WRITE(ov0[13]), .PC_HOLD(ov0[14]), .ILLEGAL(ov0[15]));

    control_unit_mc #(.EXT_ISA(0), .MULT_CYCLES(4)) dut_base (
        .CLK(CLK), .RESET(RESET0), .INSTRUCTION(instr), .INSTR_VALID(ivalid), .BUSYWAIT(busy),
        .ALUOP(ov1[2:0]), .SHIFTMODE(ov1[4:3]), .WRITEENABLE(ov1[5]), .TWOSCOMPMUX_SEL(ov1[6]),
        .IMMEDMUX_SEL(ov1[7]), .BRANCHENABLE(ov1[8]), .BNEENABLE(ov1[9]), .JUMPENABLE(ov1[10]),
        .WRITEMUX_SEL(ov1[11]), .READ(ov1[12]), .WRITE(ov1[13]), .PC_HOLD(ov1[14]), .ILLEGAL(ov1[15]));

    control_unit_mc #(.EXT_ISA(1), .MULT_CYCLES(1)) dut_m1 (
        .CLK(CLK), .RESET(RESET), .INSTRUCTION(instr), .INSTR_VALID(ivalid), .BUSYWAIT(busy),
        .ALUOP(ov2[2:0]), .SHIFTMODE(ov2[4:3]), .WRITEENABLE(ov2[5]), .TWOSCOMPMUX_SEL(ov2[6]),
        .IMMEDMUX_SEL(ov2[7]), .BRANCHENABLE(ov2[8]), .BNEENABLE(ov2[9]), .JUMPENABLE(ov2[10]),
        .WRITEMUX_SEL(ov2[11]), .READ(ov2[12]), .WRITE(ov2[13]), .PC_HOLD(ov2[14]), .ILLEGAL(ov2[15]));

    function automatic logic [15:0] outv(input int which);
        case (which)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int which, input logic [15:0] e, input logic [15:0] m, input string tag);
        q.push_back('{tag, which, e, m});
    endtask

    // Drive one cycle of stimulus, queue its expected result, then clock and drain
    task automatic step(input logic v, input logic [7:0] op, input logic bw,
                        input int which, input logic [15:0] e, input logic [15:0] m, input string tag);
        exp_t r;
        ivalid = v;
        instr  = {op, 24'($urandom)};
        busy   = bw;
        if (m != '0) push(which, e, m, tag);
        @(posedge CLK);
        #1;
        while (q.size() > 0) begin
            r = q.pop_front();
            check_vec(r.tag, outv(r.which) & r.mask, r.exp & r.mask);
        end
    endtask

    // Asynchronous reset between clock edges; outputs must clear with no edge
    task automatic rst_pulse(input int which);
        ivalid = 1'b0;
        #2;
        if (which == 1) RESET0 = 1'b1; else RESET = 1'b1;
        #1;
        if (which == 1) check_vec("async_rst_base", ov1, 16'h0000);
        else begin
            check_vec("async_rst", ov0, 16'h0000);
            check_vec("async_rst_m1", ov2, 16'h0000);
        end
        RESET  = 1'b0;
        RESET0 = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check_vec("reset", ov0, 16'h0000);
        check_vec("reset_base", ov1, 16'h0000);
        check_vec("reset_m1", ov2, 16'h0000);
        RESET  = 1'b0;
        RESET0 = 1'b0;

        // Single-cycle decode
        step(1, 8'h02, 0, 0, 16'h0001 | WE_,      M_ALL, "add");
        step(1, 8'h03, 0, 0, 16'h0001 | TW | WE_, M_ALL, "sub");
        step(1, 8'h00, 0, 0, IM | WE_,            M_ALL, "loadi");
        step(1, 8'h05, 0, 0, 16'h0003 | WE_,      M_ALL, "or");
        step(0, 8'h02, 1, 0, 16'h0003,            M_CORE, "bubble");
        step(1, 8'h04, 0, 0, 16'h0002 | WE_,      M_ALL, "and");
        step(1, 8'h07, 0, 0, 16'h0001 | TW | BR,  M_ALL, "beq");
        step(1, 8'h0C, 0, 0, 16'h0001 | TW | BN,  M_ALL, "bne");
        step(1, 8'h06, 0, 0, JP,                  M_ALL, "j");
        for (int i = 0; i < 4; i++)
            step(1, 8'(8'h0D + i), 0, 0, 16'h0005 | (16'(i) << 3) | IM | WE_, M_ALL, "shift");
        step(1, 8'h02, 0, 0, 16'h0001 | WE_, M_ALL, "add2");
        rst_pulse(0);

        // lwd miss: five busy samples in MEM, then completion with write-back
        step(1, 8'h08, 1, 0, RD | PH | WM, M_NOALU | WM | IM, "lwd_c1");
        for (int i = 0; i < 5; i++)
            step(1, 8'h02, 1, 0, RD | PH | WM, M_NOALU | WM | IM, "lwd_wait");
        step(1, 8'h02, 0, 0, WE_ | WM, M_NOALU | WM, "lwd_done");
        step(0, 8'h02, 0, 0, 16'h0000, M_NOALU, "lwd_after");
        step(1, 8'h02, 0, 0, 16'h0001 | WE_, M_ALL, "add_after_lwd");

        // swi and lwi hits: two-cycle accesses
        step(1, 8'h0B, 0, 0, WR | PH | IM, M_NOALU | IM | WM, "swi_c1");
        step(1, 8'h02, 0, 0, 16'h0000, M_NOALU, "swi_done");
        step(0, 8'h02, 0, 0, 16'h0000, M_NOALU, "swi_after");
        step(1, 8'h09, 0, 0, RD | PH | WM | IM, M_NOALU | IM | WM, "lwi_c1");
        step(1, 8'h02, 0, 0, WE_ | WM, M_NOALU | WM, "lwi_done");
        step(0, 8'h02, 0, 0, 16'h0000, M_NOALU, "lwi_after");

        // mult: 3 held cycles then write-back; single-cycle variant alongside
        push(2, 16'h0004 | WE_, M_CORE, "mult_m1");
        step(1, 8'h11, 0, 0, 16'h0004 | PH, M_CORE, "mult_c1");
        step(1, 8'h02, 0, 0, 16'h0004 | PH, M_CORE, "mult_c2");
        step(1, 8'h02, 0, 0, 16'h0004 | PH, M_CORE, "mult_c3");
        step(1, 8'h02, 0, 0, 16'h0004 | WE_, M_CORE, "mult_c4");
        step(0, 8'h02, 0, 0, 16'h0004, M_CORE, "mult_after");

        // Reset during mult cycle 2 suppresses the write-back
        step(1, 8'h11, 0, 0, 16'h0004 | PH, M_CORE, "rmult_c1");
        step(1, 8'h02, 0, 0, 16'h0004 | PH, M_CORE, "rmult_c2");
        rst_pulse(0);
        for (int i = 0; i < 4; i++)
            step(0, 8'h02, 0, 0, 16'h0000, M_ALL, "rmult_no_we");

        // Base-only instance traps extended opcodes; sticky until reset
        rst_pulse(1);
        step(1, 8'h0D, 0, 1, IL | PH, M_NOALU, "ill_base");
        for (int i = 0; i < 10; i++)
            step(1, 8'h02, 0, 1, IL | PH, M_NOALU, "ill_sticky");
        rst_pulse(1);
        step(1, 8'h02, 0, 1, 16'h0001 | WE_, M_ALL, "base_add");

        // Undefined opcode on the extended instance
        step(1, 8'hFF, 0, 0, IL | PH, M_NOALU, "undef");
        step(1, 8'h02, 0, 0, IL | PH, M_NOALU, "undef_sticky");
        step(1, 8'h08, 0, 0, IL | PH, M_NOALU, "undef_sticky2");
        rst_pulse(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
